multi_ssd: RTL
==============

# multi_ssd

Parametrised multi-channel seven-segment display controller that replaces the per-value combinational bcd/ssd pairs in the board top level. It round-robins over NUM_CH binary channels and converts each one to BCD with a sequential double-dabble engine. It then encodes the digits to active-low segment patterns and holds them in a registered hex bus. It sits between the CPU status signals (pc, sp, user registers) and the board HEX pins, clocked from the system clock and throttled by an enable strobe.

## Interface
- NUM_CH, 2, number of binary input channels (≥1)
- IN_WIDTH, 6, width of each channel value (≥1)
- DIGITS, 2, decimal digits displayed per channel (≥1)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  step enable; FSM advances only on cycles with en=1
- in  input  NUM_CH*IN_WIDTH  channel c at in[c*IN_WIDTH +: IN_WIDTH], unsigned
- hex  output  NUM_CH*DIGITS*7  channel c, digit d (0 = ones) at hex[(c*DIGITS+d)*7 +: 7], {g,f,e,d,c,b,a}, active-low
- frame  output  1  one-cycle pulse: all channels refreshed

## Operation
- Internal BCD register: BCDW = 4*((IN_WIDTH+2)/3) bits, always sufficient for 2^IN_WIDTH−1.
- FSM states:
  - LOAD: latch in[ch] into shift register; clear BCD → SHIFT.
  - SHIFT: per step, add 3 to every BCD nibble ≥5, then shift {bcd,shreg} left 1. After IN_WIDTH steps → WRITE.
  - WRITE: encode DIGITS nibbles, write channel ch field of hex; ch = (ch==NUM_CH−1) ? 0 : ch+1 → LOAD.
- Encoding (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, dash=7'h3F, blank=7'h7F.
- If DIGITS exceeds BCDW/4, the extra digits display 0.
- Channel input is sampled only in LOAD; changes during SHIFT/WRITE affect the next visit.
- Fields of channels other than ch are never disturbed.

## Timing
- Reset: state=LOAD, ch=0, hex all 7'h7F (blank), frame=0, BCD/shift registers cleared.
- Reset mid-conversion aborts the conversion and reblanks all fields; it has priority over en.
- One channel takes IN_WIDTH+2 enabled cycles; one frame takes NUM_CH*(IN_WIDTH+2) enabled cycles.
- Latency: hex field updates at the clock edge ending WRITE. Visible IN_WIDTH+2 enabled cycles after the LOAD sample.
- frame=1 for exactly one clock, the same cycle the last channel's field first shows new data. Otherwise frame=0, including while en=0.
- en=0: all state and outputs hold. Conversion resumes exactly where stopped. en has no handshake.

## Configuration
- SSD_OVF_DASH_EN defined:
  - A value needing more than DIGITS decimal digits (any BCD nibble at index ≥ DIGITS nonzero) shows dash (7'h3F) on all DIGITS of that channel.
  - Same latency, written in WRITE.
- Undefined: the low DIGITS decimal digits are shown (modulo 10^DIGITS). No overflow logic is synthesised.

## Structure
- Package ssd_pkg holds:
  - state enum (LOAD, SHIFT, WRITE)
  - the ten digit constants, SEG_DASH and SEG_BLANK
  - a function for BCDW
- Sub-module bin2bcd_seq: the double-dabble datapath (shift/add-3 registers, step counter, done flag), parametrised by IN_WIDTH. multi_ssd keeps the channel FSM, the encoder and the hex registers.

## Test plan
- Reset: defaults, assert rst 3 cycles with en=1 → hex=28'hFFFFFFF, frame=0. Release → first field update after 8 enabled cycles.
- Conversion: in ch0=37, ch1=5, en=1 always.
  - After 8 cycles: ch0 field={7'h30,7'h78}.
  - After 16 cycles: ch1 field={7'h40,7'h12}.
  - frame high exactly at cycle 16 and again at cycle 32.
- Enable gating: en toggled 1/0 every cycle → the same updates occur at 16 and 32 cycles. Outputs stay stable while en=0.
- Overflow: IN_WIDTH=8, DIGITS=2, ch0=255.
  - With SSD_OVF_DASH_EN → {7'h3F,7'h3F}.
  - Without → "55" = {7'h12,7'h12}.
  - ch0=99 → "99" in both builds.
- Boundary: IN_WIDTH=6, ch0=0 → "00". ch0=63 → "63". The ch index wraps 1→0 with NUM_CH=2. NUM_CH=1 produces frame every 8 cycles.
- Mid-operation reset and sampling:
  - rst asserted during SHIFT of ch1 → all fields blank; the next update is ch0.
  - Changing in[ch0] during its SHIFT does not alter the displayed result until the next visit.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the multi-channel seven-segment controller:
// FSM state enum, active-low segment patterns and the BCD width helper.
package ssd_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    WRITE
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One nibble per 3 binary bits always covers 2^w-1.
  function automatic int bcd_width(input int w);
    return 4 * ((w + 2) / 3);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: load latches din and clears BCD,
// each step does add-3 then shift. Ports: clk, rst, load, step, din, bcd,
// done (high on the step that completes the conversion).
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int IN_WIDTH = 6,
  localparam int BCDW = bcd_width(IN_WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [IN_WIDTH-1:0] din,
  output logic [BCDW-1:0]     bcd,
  output logic                done
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCDW-1:0]     bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCDW / 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = din;
      bcd_d   = '0;
      cnt_d   = '0;
    end else if (step) begin
      bcd_d   = {adj[BCDW-2:0], shreg_q[IN_WIDTH-1]};
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  assign bcd  = bcd_q;
  assign done = step && (cnt_q == CW'(IN_WIDTH - 1));

endmodule

// File: rtl/multi_ssd.sv
// Round-robin multi-channel seven-segment controller: converts each channel
// to BCD, encodes DIGITS active-low digits into the registered hex bus and
// pulses frame after the last channel. Ports: clk, rst, en, in, hex, frame.
// Optional macro SSD_OVF_DASH_EN: out-of-range values show dashes.
module multi_ssd
  import ssd_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH*IN_WIDTH-1:0]   in,
  output logic [NUM_CH*DIGITS*7-1:0]   hex,
  output logic                         frame
);

  localparam int BCDW = bcd_width(IN_WIDTH);
  localparam int PW   = (BCDW > DIGITS * 4) ? BCDW : DIGITS * 4;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HW   = NUM_CH * DIGITS * 7;

  state_e           state_q, state_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [HW-1:0]    hex_q, hex_d;
  logic             frame_q, frame_d;
  logic             load, step, wr, done, ovf;
  logic [IN_WIDTH-1:0] sel;
  logic [BCDW-1:0]  bcd;
  logic [PW-1:0]    pad;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CHW'(c) == ch_q)
        sel = in[c*IN_WIDTH +: IN_WIDTH];
    end
  end

  bin2bcd_seq #(
    .IN_WIDTH(IN_WIDTH)
  ) u_b2b (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .din  (sel),
    .bcd  (bcd),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      ch_q    <= '0;
      hex_q   <= {(NUM_CH*DIGITS){SEG_BLANK}};
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hex_q   <= hex_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    if (en) begin
      unique case (state_q)
        LOAD:  state_d = SHIFT;
        SHIFT: if (done) state_d = WRITE;
        WRITE: begin
          state_d = LOAD;
          ch_d = (ch_q == CHW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    load    = en && (state_q == LOAD);
    step    = en && (state_q == SHIFT);
    wr      = en && (state_q == WRITE);
    // frame is recomputed every clock so it never stretches while en=0
    frame_d = wr && (ch_q == CHW'(NUM_CH - 1));
    pad     = PW'(bcd);
`ifdef SSD_OVF_DASH_EN
    ovf     = |(pad >> (DIGITS * 4));
`else
    ovf     = 1'b0;
`endif
    hex_d   = hex_q;
    if (wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (CHW'(c) == ch_q)
            hex_d[(c*DIGITS+d)*7 +: 7] =
              ovf ? SEG_DASH : seg_enc(pad[d*4 +: 4]);
        end
      end
    end
  end

  assign hex   = hex_q;
  assign frame = frame_q;

endmodule
